// File: rtl/dispatch_pkg.sv
// Shared types and widths for the block dispatcher and its per-core slots.
package dispatch_pkg;

  localparam int DEFAULT_TPB = 4;
  localparam int TC_W        = $clog2(DEFAULT_TPB) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dispatch_state_t;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_RESET = 2'd1,
    C_BUSY  = 2'd2
  } core_slot_state_t;

endpackage

// File: rtl/dispatch_slot.sv
// One core's ownership FSM: takes a block, pulses the core reset, holds start
// until the core reports completion, and keeps the block id/count registered.
module dispatch_slot
  import dispatch_pkg::*;
#(
  parameter int TCW = TC_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           dispatch_i,
  input  logic [7:0]     block_id_i,
  input  logic [TCW-1:0] thread_count_i,
  input  logic           core_done_i,
  output logic           idle_o,
  output logic           retire_o,
  output logic           core_reset_o,
  output logic           core_start_o,
  output logic [7:0]     block_id_o,
  output logic [TCW-1:0] thread_count_o
);

  core_slot_state_t state_q, state_d;
  logic             core_reset_q, core_reset_d;
  logic             core_start_q, core_start_d;
  logic [7:0]       block_id_q, block_id_d;
  logic [TCW-1:0]   tc_q, tc_d;

  assign idle_o         = (state_q == C_IDLE);
  assign retire_o       = (state_q == C_BUSY) && core_done_i;
  assign core_reset_o   = core_reset_q;
  assign core_start_o   = core_start_q;
  assign block_id_o     = block_id_q;
  assign thread_count_o = tc_q;

  // Next-state logic; core_done is only honoured while the core owns a block.
  always_comb begin
    state_d      = state_q;
    core_reset_d = 1'b0;
    core_start_d = core_start_q;
    block_id_d   = block_id_q;
    tc_d         = tc_q;
    case (state_q)
      C_IDLE: begin
        if (dispatch_i) begin
          state_d      = C_RESET;
          core_reset_d = 1'b1;
          block_id_d   = block_id_i;
          tc_d         = thread_count_i;
        end else begin
          state_d = C_IDLE;
        end
      end
      C_RESET: begin
        state_d      = C_BUSY;
        core_start_d = 1'b1;
      end
      C_BUSY: begin
        if (core_done_i) begin
          state_d      = C_IDLE;
          core_start_d = 1'b0;
        end else begin
          state_d = C_BUSY;
        end
      end
      default: begin
        state_d      = C_IDLE;
        core_start_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= C_IDLE;
      core_reset_q <= 1'b0;
      core_start_q <= 1'b0;
      block_id_q   <= 8'd0;
      tc_q         <= {TCW{1'b0}};
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      block_id_q   <= block_id_d;
      tc_q         <= tc_d;
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel's thread count into fixed-size blocks and hands them to idle
// cores one per cycle, raising done once every dispatched block has retired.
module block_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic [7:0]                                            thread_count,
  input  logic [NUM_CORES-1:0]                                  core_done,
  output logic [NUM_CORES-1:0]                                  core_reset,
  output logic [NUM_CORES-1:0]                                  core_start,
  output logic [NUM_CORES*8-1:0]                                core_block_id,
  output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0]    core_thread_count,
  output logic                                                  done
);

  localparam int LOG2 = $clog2(THREADS_PER_BLOCK);
  localparam int TCW  = LOG2 + 1;

  dispatch_state_t      state_q, state_d;
  logic [7:0]           total_q, total_d;
  logic [7:0]           tc_lat_q, tc_lat_d;
  logic [7:0]           disp_q, disp_d;
  logic [7:0]           bdone_q, bdone_d;
  logic                 done_q, done_d;

  logic [NUM_CORES-1:0] idle_s, retire_s, dispatch_s;
  logic                 found_s, can_disp_s;
  logic [8:0]           sum_s, offset_s, remain_s;
  logic [TCW-1:0]       blk_tc_s;
  logic [7:0]           retire_cnt_s;

  assign done = done_q;

  // Block arithmetic is 9 bits wide so neither the rounding add nor the
  // remaining-thread subtraction can wrap before truncation.
  always_comb begin
    sum_s    = {1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1);
    offset_s = 9'({1'b0, disp_q} << LOG2);
    remain_s = {1'b0, tc_lat_q} - offset_s;
    if (remain_s > 9'(THREADS_PER_BLOCK)) begin
      blk_tc_s = TCW'(THREADS_PER_BLOCK);
    end else begin
      blk_tc_s = TCW'(remain_s);
    end
  end

  // Lowest-index idle core wins; retirements are summed as a popcount.
  always_comb begin
    can_disp_s   = (state_q == RUN) && (disp_q < total_q);
    dispatch_s   = {NUM_CORES{1'b0}};
    found_s      = 1'b0;
    retire_cnt_s = 8'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      dispatch_s[i] = can_disp_s & idle_s[i] & ~found_s;
      found_s       = found_s | dispatch_s[i];
      retire_cnt_s  = retire_cnt_s + {7'd0, retire_s[i]};
    end
  end

  // Top FSM; the completion test uses the updated retire count so done lands
  // one edge after the final retirement.
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    tc_lat_d = tc_lat_q;
    disp_d   = disp_q;
    bdone_d  = bdone_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          total_d  = 8'(sum_s >> LOG2);
          tc_lat_d = thread_count;
          disp_d   = 8'd0;
          bdone_d  = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        disp_d  = disp_q + {7'd0, found_s};
        bdone_d = bdone_q + retire_cnt_s;
        if (bdone_d == total_q) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Top-level registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      total_q  <= 8'd0;
      tc_lat_q <= 8'd0;
      disp_q   <= 8'd0;
      bdone_q  <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      tc_lat_q <= tc_lat_d;
      disp_q   <= disp_d;
      bdone_q  <= bdone_d;
      done_q   <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_slot #(
      .TCW(TCW)
    ) u_slot (
      .clk            (clk),
      .reset          (reset),
      .dispatch_i     (dispatch_s[g]),
      .block_id_i     (disp_q),
      .thread_count_i (blk_tc_s),
      .core_done_i    (core_done[g]),
      .idle_o         (idle_s[g]),
      .retire_o       (retire_s[g]),
      .core_reset_o   (core_reset[g]),
      .core_start_o   (core_start[g]),
      .block_id_o     (core_block_id[g*8 +: 8]),
      .thread_count_o (core_thread_count[g*TCW +: TCW])
    );
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher: every observed dispatch is matched
// against a queue of expected (core, block id, thread count) records.
module tb_block_dispatcher;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] thread_count;
  logic [1:0] core_done;
  logic [1:0] core_reset;
  logic [1:0] core_start;
  logic [15:0] core_block_id;
  logic [5:0]  core_thread_count;
  logic        done;

  typedef struct {
    int core;
    int id;
    int tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  block_dispatcher #(
    .NUM_CORES(2),
    .THREADS_PER_BLOCK(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_done         (core_done),
    .core_reset        (core_reset),
    .core_start        (core_start),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int core, input int id, input int tc);
    exp_t e;
    e.core = core;
    e.id   = id;
    e.tc   = tc;
    exp_q.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later, and score any dispatch pulses.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (core_reset[i]) begin
        chk("dispatch_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("dispatch_core", 32'(i), 32'(e.core));
          chk("dispatch_id", 32'(core_block_id[i*8 +: 8]), 32'(e.id));
          chk("dispatch_tc", 32'(core_thread_count[i*3 +: 3]), 32'(e.tc));
        end
      end
    end
  endtask

  task automatic ack(input logic [1:0] mask);
    core_done = mask;
    tick();
    core_done = 2'b00;
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    thread_count = 8'd0;
    core_done    = 2'b00;
    tick();
    tick();
    chk("rst_core_reset", 32'(core_reset), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_block_id", 32'(core_block_id), 32'd0);
    chk("rst_thread_count", 32'(core_thread_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // 8 threads: two full blocks, retired on separate edges.
    push(0, 0, 4);
    push(1, 1, 4);
    thread_count = 8'd8;
    start = 1'b1;
    tick();
    chk("t8_n_reset", 32'(core_reset), 32'd0);
    tick();
    chk("t8_n1_reset", 32'(core_reset), 32'b01);
    chk("t8_n1_start", 32'(core_start), 32'b00);
    tick();
    chk("t8_n2_reset", 32'(core_reset), 32'b10);
    chk("t8_n2_start", 32'(core_start), 32'b01);
    tick();
    chk("t8_n3_start", 32'(core_start), 32'b11);
    ack(2'b01);
    chk("t8_c0_free", 32'(core_start), 32'b10);
    chk("t8_not_done", 32'(done), 32'd0);
    ack(2'b10);
    chk("t8_m_done", 32'(done), 32'd0);
    tick();
    chk("t8_m1_done", 32'(done), 32'd1);
    chk("t8_hold_id", 32'(core_block_id[15:8]), 32'd1);
    chk("t8_hold_tc", 32'(core_thread_count[5:3]), 32'd4);
    tick();
    tick();
    chk("t8_no_relaunch", 32'(done), 32'd1);
    start = 1'b0;
    tick();
    chk("t8_done_drop", 32'(done), 32'd0);

    // 10 threads: partial last block goes to whichever core frees first.
    push(0, 0, 4);
    push(1, 1, 4);
    push(1, 2, 2);
    thread_count = 8'd10;
    start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    ack(2'b10);
    tick();
    chk("t10_blk2_reset", 32'(core_reset), 32'b10);
    tick();
    chk("t10_busy", 32'(core_start), 32'b11);
    ack(2'b01);
    chk("t10_two_left", 32'(done), 32'd0);
    ack(2'b10);
    tick();
    chk("t10_done", 32'(done), 32'd1);
    start = 1'b0;
    tick();

    // Zero threads: no core activity, done two edges after launch.
    thread_count = 8'd0;
    start = 1'b1;
    tick();
    chk("t0_n_start", 32'(core_start), 32'd0);
    tick();
    chk("t0_n1_done", 32'(done), 32'd0);
    chk("t0_n1_act", 32'({core_reset, core_start}), 32'd0);
    tick();
    chk("t0_n2_done", 32'(done), 32'd1);
    start = 1'b0;
    tick();

    // 16 threads: simultaneous retirement, refills on consecutive edges.
    push(0, 0, 4);
    push(1, 1, 4);
    push(0, 2, 4);
    push(1, 3, 4);
    thread_count = 8'd16;
    start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    ack(2'b11);
    chk("t16_both_free", 32'(core_start), 32'b00);
    tick();
    chk("t16_refill0", 32'(core_reset), 32'b01);
    tick();
    chk("t16_refill1", 32'(core_reset), 32'b10);
    tick();
    ack(2'b11);
    tick();
    chk("t16_done", 32'(done), 32'd1);
    start = 1'b0;
    tick();

    // Reset while both cores are busy, then a clean single-block launch.
    push(0, 0, 4);
    push(1, 1, 4);
    thread_count = 8'd16;
    start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("mr_start", 32'(core_start), 32'd0);
    chk("mr_reset", 32'(core_reset), 32'd0);
    chk("mr_block_id", 32'(core_block_id), 32'd0);
    chk("mr_tc", 32'(core_thread_count), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();
    push(0, 0, 4);
    thread_count = 8'd4;
    start = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_start", 32'(core_start), 32'b01);
    ack(2'b01);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    start = 1'b0;
    tick();

    // Thread count changed mid-run must not add blocks.
    push(0, 0, 4);
    push(1, 1, 4);
    thread_count = 8'd8;
    start = 1'b1;
    tick();
    thread_count = 8'd200;
    tick();
    tick();
    tick();
    ack(2'b11);
    tick();
    chk("tchg_done", 32'(done), 32'd1);
    tick();
    tick();
    chk("tchg_idle", 32'(core_start), 32'd0);
    start = 1'b0;
    tick();

    chk("pending_dispatches", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_dispatcher.md
# block_dispatcher

Consumes the kernel thread count from the device control register, splits it into fixed-size blocks, and hands those blocks out to the compute cores. It sits between the device control register and the core array. The host pulses a kernel start; the block assigns block IDs and per-block thread counts to idle cores, resets and starts each core, and collects completions. When every block has retired, it raises `done`.

## Interface
Parameters:
- `NUM_CORES`, default 2: number of compute cores served.
- `THREADS_PER_BLOCK`, default 4: threads per block. Must be a power of two, ≥1.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low. While low, all state and outputs clear at the next edge.
- `start` in 1: kernel launch request, level. Sampled only in IDLE.
- `thread_count` in 8: total kernel threads, driven by the device control register.
- `core_done` in NUM_CORES: per-core completion, level, one bit per core.
- `core_reset` out NUM_CORES: one-cycle pulse to a core before it starts a block.
- `core_start` out NUM_CORES: held high while a core owns a block.
- `core_block_id` out NUM_CORES×8: block ID assigned to each core.
- `core_thread_count` out NUM_CORES×($clog2(THREADS_PER_BLOCK)+1): active threads in the assigned block.
- `done` out 1: kernel complete. Held until `start` drops.

## Operation
- Top FSM has three states: IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1. On that edge, latch `total_blocks = ceil(thread_count / THREADS_PER_BLOCK)` (8-bit) and clear `blocks_dispatched` and `blocks_done`.
  - RUN→DONE when `blocks_done == total_blocks`. This includes `total_blocks`=0.
  - DONE→IDLE when `start`=0.
- `thread_count` changes after the IDLE→RUN edge are ignored until the next launch.
- Per-core FSM has three states: C_IDLE, C_RESET, C_BUSY.
- Dispatch happens in RUN only, at most one block per cycle. The target is the lowest-index core in C_IDLE, and only while `blocks_dispatched < total_blocks`. On a dispatch:
  - The core enters C_RESET.
  - `core_reset[i]`=1.
  - `core_block_id[i] = blocks_dispatched`.
  - `core_thread_count[i] = min(THREADS_PER_BLOCK, thread_count_latched − blocks_dispatched*THREADS_PER_BLOCK)`.
  - `blocks_dispatched` increments.
- C_RESET→C_BUSY after exactly one cycle: `core_reset[i]`=0, `core_start[i]`=1.
- In C_BUSY, `core_done[i]`=1 causes:
  - `core_start[i]`=0;
  - the core returns to C_IDLE;
  - `blocks_done` increments.
- Multiple cores may retire on the same edge; `blocks_done` adds the popcount.
- `core_done[i]` is ignored in C_IDLE and C_RESET.
- A core freed on edge E is eligible for dispatch on edge E+1.
- `core_block_id` and `core_thread_count` hold their last values after retirement.
- Arithmetic: products and differences are computed 9-bit wide to avoid wrap, then truncated.
- `total_blocks` ≤ 255, because `thread_count` ≤ 255.

## Timing
- Reset values: all outputs 0, top FSM in IDLE, all cores in C_IDLE, all counters 0.
- Launch latency: `start` sampled at edge N.
  - Core 0 `core_reset` high after edge N+1.
  - Core 0 `core_start` high after edge N+2.
  - Core k's pulse follows one cycle after core k−1's.
- Completion: if the final `blocks_done` increment occurs at edge M, `done`=1 after edge M+1.
- Zero threads: `done`=1 after edge N+2, and no `core_reset` or `core_start` activity.
- A simultaneous retirement and new dispatch to a different core on the same edge is legal.
- `reset` low mid-run: at the next edge all cores go to C_IDLE with outputs 0. No completion is reported.
- `start` held high through DONE does not relaunch. The next launch requires `start` to drop and rise again.

## Structure
- Shared package `dispatch_pkg` holds:
  - enum `dispatch_state_t` {IDLE, RUN, DONE};
  - enum `core_slot_state_t` {C_IDLE, C_RESET, C_BUSY};
  - localparam `TC_W = $clog2(THREADS_PER_BLOCK)+1`.
- One natural sub-module, `dispatch_slot`: the per-core C_IDLE/C_RESET/C_BUSY FSM plus its `block_id`/`thread_count` registers. It is instantiated NUM_CORES times.
- The top module holds the priority picker, the counters and the top FSM.

## Test plan
- NUM_CORES=2, TPB=4, `thread_count`=8:
  - core0 gets id 0 / count 4;
  - core1 gets id 1 / count 4;
  - ack both → `done`=1 two edges after the last `core_done`.
- `thread_count`=10:
  - 3 blocks;
  - after core1 finishes first, block 2 (count 2) goes to core1;
  - `done` only after all three retire.
- `thread_count`=0 → no `core_reset` or `core_start` pulses; `done`=1 exactly two edges after `start` is sampled.
- Both `core_done` asserted on the same edge with `thread_count`=16 → `blocks_done` +2; blocks 2 and 3 dispatched on consecutive edges to core0 then core1.
- `reset` low while both cores are busy → all outputs 0 next edge. A fresh launch with `thread_count`=4 completes normally with block 0 on core0.
- `thread_count` changed from 8 to 200 during RUN → still exactly 2 blocks dispatched.
